instruction_fetch: RTL

//   Fetch stage directly upstream of the opcode decoder. Owns the program counter,

---
 rtl/instruction_fetch.sv | 83 ++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one read at a time, and holds a single instruction
// for the decoder behind a valid/ready handshake. Counts retired instructions.
module instruction_fetch #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              halt,
    output logic              halted,
    output logic [ADDR_W-1:0] pc,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [1:0] {FETCH, ISSUE, HALT} state_t;

    state_t state, state_n;
    logic   armed;
    logic   fetch_done;
    logic   issue_done;

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_n;
    end

    // Outputs decode only registered state; inputs steer state_n alone.
    always_comb begin
        state_n     = state;
        mem_req     = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        fetch_done  = 1'b0;
        issue_done  = 1'b0;
        case (state)
            FETCH: begin
                mem_req    = armed;
                fetch_done = armed && mem_ack;
                if (fetch_done) state_n = ISSUE;
            end
            ISSUE: begin
                instr_valid = 1'b1;
                issue_done  = instr_ready;
                if (issue_done) state_n = halt ? HALT : FETCH;
            end
            HALT: begin
                halted = 1'b1;
                if (!halt) state_n = FETCH;
            end
            default: state_n = FETCH;
        endcase
    end

    assign mem_addr = pc;

    // armed keeps mem_req low through reset and rises on the first clock after release.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed   <= 1'b0;
            pc      <= '0;
            instr   <= '0;
            retired <= '0;
        end else begin
            armed <= 1'b1;
            if (fetch_done) instr <= mem_rdata;
            if (issue_done) begin
                retired <= retired + 1'b1;
                pc      <= jump_en ? jump_addr : pc + 1'b1;
            end
        end
    end

endmodule
